mem_store_unit: RTL and testbench
=================================

# mem_store_unit

Parametrised store path between the datapath and the data memory port. It decodes the store opcode into an access size and lane-aligns the data and byte enables for any byte address. A store that crosses a bus-word boundary is split into two memory beats. Accepted stores are buffered in a small in-order queue behind a valid/ready handshake, so the core is not stalled by a slow memory.

## Interface
- DATA_W, 64: memory bus width in bits; NB = DATA_W/8 byte lanes; power of two, ≥ 64.
- ADDR_W, 64: byte-address width.
- DEPTH, 4: store-queue entries; power of two, ≥ 2.
- ALLOW_MISALIGN, 1: 1 splits boundary-crossing stores; 0 rejects any store whose address is not a multiple of its size.
- iCLK  in  1  clock; all state changes on the rising edge.
- iRSTn  in  1  asynchronous, active-low reset.
- iReqValid  in  1  store request present.
- oReqReady  out  1  queue can accept.
- iOpcode  in  11  LEGv8 opcode (OPC_D_STUR/STURW/STURH/STURB).
- iAddr  in  ADDR_W  byte address.
- iData  in  DATA_W  store data, right-justified.
- oMemValid  out  1  beat present on the memory port.
- iMemReady  in  1  memory accepts the beat.
- oMemAddr  out  ADDR_W  bus-aligned beat address (low log2(NB) bits zero).
- oMemData  out  DATA_W  lane-positioned data.
- oMemByteEnable  out  NB  active-high lane enables.
- oMisalignErr  out  1  one-cycle pulse when a request is rejected.
- oCount  out  $clog2(DEPTH)+1  occupied entries.
- oBusy  out  1  queue non-empty or beat in flight.

## Operation
- Acceptance: handshake when iReqValid && oReqReady. oReqReady = (count < DEPTH), independent of iReqValid and of any same-cycle pop.
- Opcode decode to size in bytes: STURB=1, STURH=2, STURW=4, STUR=8. A non-store opcode with a valid handshake is consumed and discarded: no enqueue, no error.
- Size is truncated: data keeps iData[8*size-1:0]; upper bits are zeroed before shifting.
- off = iAddr[log2(NB)-1:0]. wide_data (2*DATA_W) = truncated data << 8*off. wide_be (2*NB) = ((1<<size)-1) << off.
- Entry = {base = iAddr with low bits cleared, wide_data, wide_be, split = |wide_be[2NB-1:NB]}.
- ALLOW_MISALIGN=0 and iAddr mod size ≠ 0: the request is consumed, not enqueued, and oMisalignErr pulses in the next cycle.
- Drain FSM with states S_IDLE, S_LO and S_HI:
  - S_IDLE → S_LO when the queue is non-empty.
  - S_LO presents base, the low halves of data and BE. On handshake: → S_HI if split, otherwise pop and go to S_LO if more entries remain, else S_IDLE.
  - S_HI presents base+NB (mod 2^ADDR_W), the high halves. On handshake: pop, then → S_LO or S_IDLE.
- Beats are in order, low beat before high beat. Beats of one entry are never interleaved with beats of another entry.
- Once oMemValid is high, its payload is held stable until iMemReady.

## Timing
- Reset (asynchronous assert, synchronous release): queue empty, FSM S_IDLE. Outputs after reset:
  - oMemValid=0, oMemAddr=0, oMemData=0, oMemByteEnable=0
  - oMisalignErr=0, oCount=0, oBusy=0, oReqReady=1
- Reset asserted mid-beat flushes all entries. A partially sent split store is abandoned; no completion is owed.
- Latency: a request accepted at edge N gives oMemValid=1 after edge N+1, provided the queue was empty and the FSM was in S_IDLE. There is no combinational bypass from request to memory port.
- Throughput: one beat per cycle while iMemReady=1. Non-split stores drain at 1/cycle, split stores at 2 cycles each.
- Simultaneous push and pop: count unchanged. A pop that frees a slot when the queue is full is visible on oReqReady only from the next cycle.
- Queue pointers wrap modulo DEPTH. Full and empty are distinguished by the extra count bit.
- oMisalignErr is registered, high for exactly one cycle per rejected request.

## Structure
- Shared package mem_pkg:
  - store-size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - function opc_to_size(iOpcode), reusing the existing OPC_D_STUR* constants from Parametros.v
  - typedef store_entry_t.
- Sub-module store_fifo: a parametrised DEPTH×entry synchronous FIFO with push/pop/full/empty/count. The aligner and drain FSM stay in the top level.

## Test plan
(all with DATA_W=64, DEPTH=4, iMemReady=1 unless stated)
- STUR at 0x100, data 0x1122334455667788 → one beat: addr 0x100, data 0x1122334455667788, BE 0xFF, oMemValid high one cycle after accept.
- STURH at 0x10B, data 0xFFFFFFFFFFFFABCD → one beat: addr 0x108, data 0x000000ABCD000000, BE 0x18.
- STURW at 0x206, data 0xDEADBEEF, ALLOW_MISALIGN=1 → beat0: addr 0x200, data 0xBEEF000000000000, BE 0xC0. Beat1: addr 0x208, data 0x000000000000DEAD, BE 0x03.
- Same request with ALLOW_MISALIGN=0 → no beat, oMisalignErr pulses once, oCount stays 0.
- iMemReady=0 and five back-to-back STURBs → oReqReady drops after the 4th, oCount=4. oMemAddr/Data/BE stay stable. Raising iMemReady drains the 4 entries in order, one per cycle.
- Assert iRSTn=0 during beat1 of a split store → next cycle oMemValid=0, oCount=0, oBusy=0, oReqReady=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared store-path types: opcode constants, access sizes,
// drain FSM states and the store-queue entry layout.
package mem_pkg;

   localparam logic [10:0] OPC_D_STUR  = 11'b11111000000;
   localparam logic [10:0] OPC_D_STURW = 11'b10111000000;
   localparam logic [10:0] OPC_D_STURH = 11'b01111000000;
   localparam logic [10:0] OPC_D_STURB = 11'b00111000000;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W,
      SZ_D
   } st_size_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI
   } drain_state_e;

   // Entry layout for the default 64-bit bus build.
   localparam int ST_DATA_W = 64;
   localparam int ST_ADDR_W = 64;
   localparam int ST_NB     = ST_DATA_W / 8;

   typedef struct packed {
      logic [ST_ADDR_W-1:0]   base;
      logic [2*ST_DATA_W-1:0] wdata;
      logic [2*ST_NB-1:0]     wbe;
      logic                   split;
   } store_entry_t;

   function automatic logic is_store(input logic [10:0] iOpcode);
      return (iOpcode == OPC_D_STUR)  || (iOpcode == OPC_D_STURW) ||
             (iOpcode == OPC_D_STURH) || (iOpcode == OPC_D_STURB);
   endfunction

   function automatic st_size_e opc_to_size(input logic [10:0] iOpcode);
      st_size_e sz;
      sz = SZ_D;
      unique case (1'b1)
         (iOpcode == OPC_D_STURB): sz = SZ_B;
         (iOpcode == OPC_D_STURH): sz = SZ_H;
         (iOpcode == OPC_D_STURW): sz = SZ_W;
         default:                  sz = SZ_D;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/store_fifo.sv
// In-order DEPTH x W store queue; the extra count bit
// separates full from empty while pointers wrap.
module store_fifo
   import mem_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [W-1:0]             data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/mem_store_unit.sv
// Store path: decode, lane-align, queue, and drain to the
// memory port as one or two beats per store.
module mem_store_unit
   import mem_pkg::*;
#(
   parameter int DATA_W         = 64,
   parameter int ADDR_W         = 64,
   parameter int DEPTH          = 4,
   parameter int ALLOW_MISALIGN = 1
) (
   input  logic                   iCLK,
   input  logic                   iRSTn,
   input  logic                   iReqValid,
   output logic                   oReqReady,
   input  logic [10:0]            iOpcode,
   input  logic [ADDR_W-1:0]      iAddr,
   input  logic [DATA_W-1:0]      iData,
   output logic                   oMemValid,
   input  logic                   iMemReady,
   output logic [ADDR_W-1:0]      oMemAddr,
   output logic [DATA_W-1:0]      oMemData,
   output logic [DATA_W/8-1:0]    oMemByteEnable,
   output logic                   oMisalignErr,
   output logic [$clog2(DEPTH):0] oCount,
   output logic                   oBusy
);

   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]   base;
      logic [2*DATA_W-1:0] wdata;
      logic [2*NB-1:0]     wbe;
      logic                split;
   } entry_t;

   localparam int EW = $bits(entry_t);

   st_size_e            sz;
   logic                st_ok, misal, reject, fire, push, pop;
   logic [OW-1:0]       off;
   logic [2*DATA_W-1:0] trunc;
   logic [7:0]          be_base;
   logic [2*NB-1:0]     wbe;
   entry_t              in_e, head;
   logic                full, empty, remain;
   logic [CW-1:0]       count;
   drain_state_e        state_q, state_d;
   logic                err_q, err_d;

   // Decode size, truncate data and lane-align data/enables.
   always_comb begin
      sz    = opc_to_size(iOpcode);
      st_ok = is_store(iOpcode);
      off   = iAddr[OW-1:0];
      trunc = '0;
      be_base = 8'h00;
      misal = 1'b0;
      unique case (sz)
         SZ_B: begin
            trunc   = {{(2*DATA_W-8){1'b0}}, iData[7:0]};
            be_base = 8'h01;
         end
         SZ_H: begin
            trunc   = {{(2*DATA_W-16){1'b0}}, iData[15:0]};
            be_base = 8'h03;
            misal   = iAddr[0];
         end
         SZ_W: begin
            trunc   = {{(2*DATA_W-32){1'b0}}, iData[31:0]};
            be_base = 8'h0F;
            misal   = |iAddr[1:0];
         end
         SZ_D: begin
            trunc   = {{(2*DATA_W-64){1'b0}}, iData[63:0]};
            be_base = 8'hFF;
            misal   = |iAddr[2:0];
         end
      endcase
      wbe        = {{(2*NB-8){1'b0}}, be_base} << off;
      in_e.base  = {iAddr[ADDR_W-1:OW], {OW{1'b0}}};
      in_e.wdata = trunc << {off, 3'b000};
      in_e.wbe   = wbe;
      in_e.split = |wbe[2*NB-1:NB];
   end

   assign oReqReady = !full;
   assign fire      = iReqValid && oReqReady;
   assign reject    = st_ok && misal && (ALLOW_MISALIGN == 0);
   assign push      = fire && st_ok && !reject;
   assign err_d     = fire && reject;
   assign oMisalignErr = err_q;
   assign oCount    = count;
   assign oBusy     = !empty || (state_q != S_IDLE);

   store_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (iCLK),
      .rst_ni  (iRSTn),
      .push_i  (push),
      .data_i  (in_e),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // Drain state and registered reject pulse.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // Beat selection and next state; a split head stays queued
   // until its high beat is taken, so entries never interleave.
   always_comb begin
      state_d        = state_q;
      pop            = 1'b0;
      oMemValid      = 1'b0;
      oMemAddr       = '0;
      oMemData       = '0;
      oMemByteEnable = '0;
      remain         = (count > CW'(1)) || push;
      case (state_q)
         S_IDLE: begin
            if (!empty) state_d = S_LO;
         end
         S_LO: begin
            oMemValid      = 1'b1;
            oMemAddr       = head.base;
            oMemData       = head.wdata[DATA_W-1:0];
            oMemByteEnable = head.wbe[NB-1:0];
            if (iMemReady) begin
               if (head.split) begin
                  state_d = S_HI;
               end else begin
                  pop     = 1'b1;
                  state_d = remain ? S_LO : S_IDLE;
               end
            end
         end
         S_HI: begin
            oMemValid      = 1'b1;
            oMemAddr       = head.base + ADDR_W'(NB);
            oMemData       = head.wdata[2*DATA_W-1:DATA_W];
            oMemByteEnable = head.wbe[2*NB-1:NB];
            if (iMemReady) begin
               pop     = 1'b1;
               state_d = remain ? S_LO : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: one DUT splitting
// misaligned stores, one rejecting them.
module tb_mem_store_unit;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        va, vb, mrdy;
   logic [10:0] opc;
   logic [63:0] addr, data;

   logic        a_rdy, a_mv, a_err, a_busy;
   logic [63:0] a_addr, a_data;
   logic [7:0]  a_be;
   logic [2:0]  a_cnt;

   logic        b_rdy, b_mv, b_err, b_busy;
   logic [63:0] b_addr, b_data;
   logic [7:0]  b_be;
   logic [2:0]  b_cnt;

   int tests = 0;
   int fails = 0;

   logic [136:0] exp_beat;

   always #5 clk = ~clk;

   mem_store_unit #(.ALLOW_MISALIGN(1)) u_dut (
      .iCLK(clk), .iRSTn(rst_n), .iReqValid(va), .oReqReady(a_rdy),
      .iOpcode(opc), .iAddr(addr), .iData(data),
      .oMemValid(a_mv), .iMemReady(mrdy), .oMemAddr(a_addr),
      .oMemData(a_data), .oMemByteEnable(a_be),
      .oMisalignErr(a_err), .oCount(a_cnt), .oBusy(a_busy)
   );

   mem_store_unit #(.ALLOW_MISALIGN(0)) u_rej (
      .iCLK(clk), .iRSTn(rst_n), .iReqValid(vb), .oReqReady(b_rdy),
      .iOpcode(opc), .iAddr(addr), .iData(data),
      .oMemValid(b_mv), .iMemReady(mrdy), .oMemAddr(b_addr),
      .oMemData(b_data), .oMemByteEnable(b_be),
      .oMisalignErr(b_err), .oCount(b_cnt), .oBusy(b_busy)
   );

   // Present one request on DUT A for one clock edge.
   task automatic send(input logic [10:0] o, input logic [63:0] a,
                       input logic [63:0] d);
      opc  = o;
      addr = a;
      data = d;
      va   = 1'b1;
      @(negedge clk);
      va   = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      va = 0; vb = 0; mrdy = 1; opc = '0; addr = '0; data = '0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({a_mv, a_addr, a_data, a_be} !== 137'd0) begin
         fails++;
         $display("FAIL reset_port got %h want 0", {a_mv, a_addr, a_data, a_be});
      end
      tests++;
      if ({a_err, a_cnt, a_busy, a_rdy} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_status got %b want 000001",
                  {a_err, a_cnt, a_busy, a_rdy});
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({a_mv, a_err, a_cnt, a_busy, a_rdy, b_rdy} !==
          {1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL post_reset got %b want 00000011",
                  {a_mv, a_err, a_cnt, a_busy, a_rdy, b_rdy});
      end
   endtask

   task automatic test_stur;
      send(OPC_D_STUR, 64'h100, 64'h1122334455667788);
      tests++;
      if ({a_mv, a_cnt} !== {1'b0, 3'd1}) begin
         fails++;
         $display("FAIL stur_no_bypass got mv=%b cnt=%0d want mv=0 cnt=1",
                  a_mv, a_cnt);
      end
      @(negedge clk);
      exp_beat = {1'b1, 64'h100, 64'h1122334455667788, 8'hFF};
      tests++;
      if ({a_mv, a_addr, a_data, a_be} !== exp_beat) begin
         fails++;
         $display("FAIL stur_beat got %h want %h",
                  {a_mv, a_addr, a_data, a_be}, exp_beat);
      end
      @(negedge clk);
      tests++;
      if ({a_mv, a_busy, a_cnt} !== 5'd0) begin
         fails++;
         $display("FAIL stur_done got %b want 00000", {a_mv, a_busy, a_cnt});
      end
   endtask

   task automatic test_sturh;
      send(OPC_D_STURH, 64'h10B, 64'hFFFFFFFFFFFFABCD);
      @(negedge clk);
      exp_beat = {1'b1, 64'h108, 64'h000000ABCD000000, 8'h18};
      tests++;
      if ({a_mv, a_addr, a_data, a_be} !== exp_beat) begin
         fails++;
         $display("FAIL sturh_beat got %h want %h",
                  {a_mv, a_addr, a_data, a_be}, exp_beat);
      end
      @(negedge clk);
      tests++;
      if ({a_mv, a_busy} !== 2'b00) begin
         fails++;
         $display("FAIL sturh_done got %b want 00", {a_mv, a_busy});
      end
   endtask

   task automatic test_split;
      send(OPC_D_STURW, 64'h206, 64'hDEADBEEF);
      @(negedge clk);
      exp_beat = {1'b1, 64'h200, 64'hBEEF000000000000, 8'hC0};
      tests++;
      if ({a_mv, a_addr, a_data, a_be} !== exp_beat) begin
         fails++;
         $display("FAIL split_beat0 got %h want %h",
                  {a_mv, a_addr, a_data, a_be}, exp_beat);
      end
      @(negedge clk);
      exp_beat = {1'b1, 64'h208, 64'h000000000000DEAD, 8'h03};
      tests++;
      if ({a_mv, a_addr, a_data, a_be} !== exp_beat) begin
         fails++;
         $display("FAIL split_beat1 got %h want %h",
                  {a_mv, a_addr, a_data, a_be}, exp_beat);
      end
      @(negedge clk);
      tests++;
      if ({a_mv, a_busy, a_cnt} !== 5'd0) begin
         fails++;
         $display("FAIL split_done got %b want 00000", {a_mv, a_busy, a_cnt});
      end
   endtask

   task automatic test_misalign_reject;
      opc  = OPC_D_STURW;
      addr = 64'h206;
      data = 64'hDEADBEEF;
      vb   = 1'b1;
      @(negedge clk);
      vb   = 1'b0;
      tests++;
      if ({b_err, b_cnt, b_mv} !== {1'b1, 3'd0, 1'b0}) begin
         fails++;
         $display("FAIL reject_pulse got err=%b cnt=%0d mv=%b want 1 0 0",
                  b_err, b_cnt, b_mv);
      end
      @(negedge clk);
      tests++;
      if ({b_err, b_cnt, b_mv, b_busy} !== 6'd0) begin
         fails++;
         $display("FAIL reject_after got %b want 000000",
                  {b_err, b_cnt, b_mv, b_busy});
      end
   endtask

   task automatic test_nonstore;
      send(11'h000, 64'h500, 64'h55);
      tests++;
      if ({a_cnt, a_err, a_busy} !== 5'd0) begin
         fails++;
         $display("FAIL nonstore got %b want 00000", {a_cnt, a_err, a_busy});
      end
      @(negedge clk);
      tests++;
      if (a_mv !== 1'b0) begin
         fails++;
         $display("FAIL nonstore_beat got %b want 0", a_mv);
      end
   endtask

   task automatic test_back_to_back;
      logic [136:0] e0;
      e0 = {1'b1, 64'h300, 64'h00000000000000A0, 8'h01};
      mrdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (a_rdy !== (i < 4)) begin
            fails++;
            $display("FAIL b2b_ready[%0d] got %b want %b", i, a_rdy, i < 4);
         end
         if (i >= 2) begin
            tests++;
            if ({a_mv, a_addr, a_data, a_be} !== e0) begin
               fails++;
               $display("FAIL b2b_stable[%0d] got %h want %h", i,
                        {a_mv, a_addr, a_data, a_be}, e0);
            end
         end
         opc  = OPC_D_STURB;
         addr = 64'h300 + 64'(9 * i);
         data = 64'hFFFFFFFFFFFFFF00 | 64'(8'hA0 + i);
         va   = 1'b1;
         @(negedge clk);
      end
      va = 1'b0;
      tests++;
      if ({a_cnt, a_rdy} !== {3'd4, 1'b0}) begin
         fails++;
         $display("FAIL b2b_full got cnt=%0d rdy=%b want 4 0", a_cnt, a_rdy);
      end
      mrdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_beat = {1'b1, 64'h300 + 64'(8 * k),
                     64'(8'hA0 + k) << (8 * k), 8'(1 << k)};
         tests++;
         if ({a_mv, a_addr, a_data, a_be} !== exp_beat ||
             a_cnt !== 3'(4 - k)) begin
            fails++;
            $display("FAIL b2b_drain[%0d] got %h cnt=%0d want %h cnt=%0d", k,
                     {a_mv, a_addr, a_data, a_be}, a_cnt, exp_beat, 4 - k);
         end
         @(negedge clk);
      end
      tests++;
      if ({a_mv, a_cnt, a_busy} !== 5'd0) begin
         fails++;
         $display("FAIL b2b_empty got %b want 00000", {a_mv, a_cnt, a_busy});
      end
   endtask

   task automatic test_reset_mid;
      mrdy = 1'b1;
      send(OPC_D_STURW, 64'h206, 64'hDEADBEEF);
      send(OPC_D_STUR, 64'h400, 64'h0123456789ABCDEF);
      tests++;
      if ({a_mv, a_addr} !== {1'b1, 64'h200}) begin
         fails++;
         $display("FAIL mid_beat0 got mv=%b addr=%h want 1 200", a_mv, a_addr);
      end
      @(negedge clk);
      tests++;
      if ({a_mv, a_addr, a_cnt} !== {1'b1, 64'h208, 3'd2}) begin
         fails++;
         $display("FAIL mid_beat1 got mv=%b addr=%h cnt=%0d want 1 208 2",
                  a_mv, a_addr, a_cnt);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({a_mv, a_cnt, a_busy, a_rdy} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL mid_async got %b want 000001",
                  {a_mv, a_cnt, a_busy, a_rdy});
      end
      @(negedge clk);
      tests++;
      if ({a_mv, a_cnt, a_busy, a_rdy} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL mid_flush got %b want 000001",
                  {a_mv, a_cnt, a_busy, a_rdy});
      end
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({a_mv, a_busy, a_cnt} !== 5'd0) begin
         fails++;
         $display("FAIL mid_abandon got %b want 00000", {a_mv, a_busy, a_cnt});
      end
   endtask

   initial begin
      test_reset;
      test_stur;
      test_sturh;
      test_split;
      test_misalign_reject;
      test_nonstore;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
